// File: rtl/aibnd_dll_ctrl_if.sv
// Signal bundle between the DLL loop controller and its environment.
// The slave modport is the controller's view; master is the driver/observer side.
interface aibnd_dll_ctrl_if;
    logic       dll_en;
    logic       rb_cont_cal;
    logic       t_up;
    logic       t_down;
    logic       dll_reset_n;
    logic [2:0] i_gray;
    logic [6:0] f_gray;
    logic       dll_lock;
    logic [9:0] pvt_ref_half_gry;
    logic       dll_err;
    logic [9:0] code_bin;

    modport master (
        output dll_en, rb_cont_cal, t_up, t_down,
        input  dll_reset_n, i_gray, f_gray, dll_lock, pvt_ref_half_gry, dll_err, code_bin
    );

    modport slave (
        input  dll_en, rb_cont_cal, t_up, t_down,
        output dll_reset_n, i_gray, f_gray, dll_lock, pvt_ref_half_gry, dll_err, code_bin
    );
endinterface

// File: rtl/aibnd_dll_ctrl.sv
// DLL loop controller: windowed phase-detector voting steps a 10-bit delay code,
// detects lock by dithering, flags sustained saturation, and sequences the PD reset.
module aibnd_dll_ctrl #(
    parameter int         WIN       = 16,
    parameter int         SETTLE    = 8,
    parameter int         LOCK_REV  = 4,
    parameter int         SAT_LIM   = 4,
    parameter logic [9:0] INIT_CODE = 10'd512
) (
    input  logic             clk_dcd,
    input  logic             dll_reset,
    aibnd_dll_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(WIN) + 1;
    localparam int PH_W  = 16;
    localparam int REV_W = $clog2(LOCK_REV + 1);
    localparam int SAT_W = $clog2(SAT_LIM + 1);
    localparam logic [CNT_W-1:0] HALF_WIN = CNT_W'(WIN / 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_SETTLE,
        ST_SAMPLE,
        ST_UPDATE,
        ST_LOCKED
    } state_t;

    state_t           state;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] up_cnt;
    logic [CNT_W-1:0] dn_cnt;
    logic [REV_W-1:0] rev_cnt;
    logic [SAT_W-1:0] sat_cnt;
    logic             last_valid;
    logic             last_up;
    logic [9:0]       code;
    logic             up_meta, up_sync, dn_meta, dn_sync;
    logic             pd_rstn;
    logic [2:0]       i_gray_r;
    logic [6:0]       f_gray_r;
    logic             lock_r;
    logic [9:0]       pvt_r;
    logic             err_r;

    logic             up_vote, dn_vote;
    logic             dir_up, dir_dn;
    logic             sat_hit;
    logic             rev_hit;
    logic [9:0]       code_next;
    logic [9:0]       half;
    logic [REV_W-1:0] rev_next;
    logic [SAT_W-1:0] sat_next;

    function automatic logic [2:0] gray3(input logic [2:0] x);
        return x ^ (x >> 1);
    endfunction

    function automatic logic [6:0] gray7(input logic [6:0] x);
        return x ^ (x >> 1);
    endfunction

    // Decision for the window just closed; only consumed in UPDATE.
    always_comb begin
        up_vote   = up_sync & ~dn_sync;
        dn_vote   = dn_sync & ~up_sync;
        dir_up    = (up_cnt > HALF_WIN);
        dir_dn    = (dn_cnt > HALF_WIN);
        sat_hit   = (dir_up && code == 10'd1023) || (dir_dn && code == 10'd0);
        code_next = code;
        if (!sat_hit) begin
            if (dir_up)
                code_next = code + 10'd1;
            else if (dir_dn)
                code_next = code - 10'd1;
        end
        rev_hit = 1'b0;
        if (!lock_r) begin
            if (!dir_up && !dir_dn)
                rev_hit = 1'b1;
            else if (!sat_hit && last_valid && (dir_up != last_up))
                rev_hit = 1'b1;
        end
        rev_next = rev_cnt + REV_W'(rev_hit);
        if (!sat_hit)
            sat_next = '0;
        else if (sat_cnt == SAT_W'(SAT_LIM))
            sat_next = sat_cnt;
        else
            sat_next = sat_cnt + SAT_W'(1);
        half = code_next >> 1;
    end

    always_ff @(posedge clk_dcd) begin
        if (dll_reset) begin
            state      <= ST_IDLE;
            phase      <= '0;
            up_cnt     <= '0;
            dn_cnt     <= '0;
            rev_cnt    <= '0;
            sat_cnt    <= '0;
            last_valid <= 1'b0;
            last_up    <= 1'b0;
            code       <= INIT_CODE;
            up_meta    <= 1'b0;
            up_sync    <= 1'b0;
            dn_meta    <= 1'b0;
            dn_sync    <= 1'b0;
            pd_rstn    <= 1'b0;
            i_gray_r   <= gray3(INIT_CODE[9:7]);
            f_gray_r   <= gray7(INIT_CODE[6:0]);
            lock_r     <= 1'b0;
            pvt_r      <= '0;
            err_r      <= 1'b0;
        end else begin
            up_meta  <= bus.t_up;
            up_sync  <= up_meta;
            dn_meta  <= bus.t_down;
            dn_sync  <= dn_meta;
            i_gray_r <= gray3(code[9:7]);
            f_gray_r <= gray7(code[6:0]);

            if (!bus.dll_en) begin
                state      <= ST_IDLE;
                phase      <= '0;
                up_cnt     <= '0;
                dn_cnt     <= '0;
                rev_cnt    <= '0;
                sat_cnt    <= '0;
                last_valid <= 1'b0;
                last_up    <= 1'b0;
                pd_rstn    <= 1'b0;
                lock_r     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        pd_rstn <= 1'b0;
                        phase   <= '0;
                        state   <= ST_CLR;
                    end
                    ST_CLR: begin
                        if (phase == PH_W'(1)) begin
                            phase   <= '0;
                            pd_rstn <= 1'b1;
                            state   <= ST_SETTLE;
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                    ST_SETTLE: begin
                        if (phase == PH_W'(SETTLE - 1)) begin
                            phase <= '0;
                            state <= ST_SAMPLE;
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                    ST_SAMPLE: begin
                        up_cnt <= up_cnt + CNT_W'(up_vote);
                        dn_cnt <= dn_cnt + CNT_W'(dn_vote);
                        if (phase == PH_W'(WIN - 1)) begin
                            phase <= '0;
                            state <= ST_UPDATE;
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                    ST_UPDATE: begin
                        code    <= code_next;
                        sat_cnt <= sat_next;
                        up_cnt  <= '0;
                        dn_cnt  <= '0;
                        rev_cnt <= rev_next;
                        if (sat_next == SAT_W'(SAT_LIM))
                            err_r <= 1'b1;
                        if (dir_up || dir_dn) begin
                            last_valid <= 1'b1;
                            last_up    <= dir_up;
                        end
                        // Lock entry captures the half-period reference from the new code.
                        if (!lock_r && rev_next == REV_W'(LOCK_REV)) begin
                            state   <= ST_LOCKED;
                            lock_r  <= 1'b1;
                            pvt_r   <= {gray7(half[6:0]), gray3(half[9:7])};
                            pd_rstn <= 1'b1;
                        end else if (lock_r && !bus.rb_cont_cal) begin
                            state   <= ST_LOCKED;
                            pd_rstn <= 1'b1;
                        end else begin
                            state   <= ST_CLR;
                            pd_rstn <= 1'b0;
                        end
                    end
                    ST_LOCKED: begin
                        phase <= '0;
                        if (bus.rb_cont_cal) begin
                            pd_rstn <= 1'b0;
                            state   <= ST_CLR;
                        end else begin
                            pd_rstn <= 1'b1;
                        end
                    end
                    default: begin
                        pd_rstn <= 1'b0;
                        state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.dll_reset_n      = pd_rstn;
    assign bus.i_gray           = i_gray_r;
    assign bus.f_gray           = f_gray_r;
    assign bus.dll_lock         = lock_r;
    assign bus.pvt_ref_half_gry = pvt_r;
    assign bus.dll_err          = err_r;
    assign bus.code_bin         = code;

endmodule
